lif_array_uart: RTL and testbench
=================================

LIF_ARRAY_UART -- requirements
Module: lif_array_uart

Interface
REQ-001 SHALL have parameter N_NEURONS, default 4, number of neurons (1..64).
REQ-002 SHALL have parameter VW, default 8, membrane width in bits (8..16).
REQ-003 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (>=4).
REQ-004 SHALL have port CLK  input  1  the single clock; all logic rises on it.
REQ-005 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-006 SHALL have port RXD  input  1  asynchronous UART serial input, 8N1, LSB first, idle high.
REQ-007 SHALL have port spikes  output  N_NEURONS  one-cycle spike pulse per neuron.
REQ-008 SHALL have port rx_data  output  8  last correctly framed received byte.
REQ-009 SHALL have port rx_valid  output  1  one-cycle pulse per correctly framed byte.
REQ-010 SHALL have port frame_err  output  1  sticky flag, set when a stop bit samples low.
REQ-011 SHALL have port logs  output  8  total spike count, modulo 256.

Function
REQ-012 SHALL pass RXD through a 2-flop synchroniser before any use.
REQ-013 SHALL run UART RX FSM IDLE -> START -> DATA -> STOP -> IDLE, leaving IDLE on a synchronised falling edge.
REQ-014 SHALL sample START at CLKS_PER_BIT/2 cycles; a high sample returns the FSM to IDLE with no output (false start).
REQ-015 SHALL sample each of the 8 data bits and the stop bit every CLKS_PER_BIT cycles after the start-bit mid sample.
REQ-016 SHALL, on stop bit high, load rx_data and pulse rx_valid for exactly one cycle; on stop bit low, set frame_err, leave rx_data unchanged, suppress rx_valid, and present no byte to the parser.
REQ-017 SHALL use a two-state parser, CMD and ARG, with each valid byte alternating the state; a command byte is [7:6] opcode, [5:0] index.
REQ-018 SHALL implement opcode 00 as ARG byte -> weight[index], signed 8-bit.
REQ-019 SHALL implement opcode 01 as ARG byte -> threshold[index], unsigned 8-bit, zero-extended to VW; a threshold of 0 disables firing for that neuron.
REQ-020 SHALL implement opcode 10 as ARG[3:0] -> global leak shift L; L >= VW gives zero leak.
REQ-021 SHALL implement opcode 11 as a tick: ARG bit i (i < min(N_NEURONS,8)) gates input to neuron i; neurons i >= 8 receive no input and only leak.
REQ-022 SHALL consume the ARG byte of an opcode 00/01 with index >= N_NEURONS without changing any state.
REQ-023 SHALL compute, on a tick, per neuron: t = v - (v >> L) + (gate ? sext(weight) : 0), evaluated at VW+2 bits signed.
REQ-024 SHALL saturate t to the range [0, 2^VW-1] to give the new membrane value.
REQ-025 SHALL, when threshold != 0 and saturated t >= threshold, set v to 0 and assert spikes[i]; otherwise set v to saturated t.
REQ-026 SHALL make the tick take effect one cycle after its ARG rx_valid: membranes and spikes update in cycle T+1, and spikes is high for that cycle only.
REQ-027 SHALL add popcount(spikes) to logs in the cycle after the spike, wrapping modulo 256.
REQ-028 SHALL keep spikes at 0 and membranes unchanged in every non-tick cycle.
REQ-029 SHALL accept a new start bit in the cycle after returning from STOP; the back-to-back byte is processed normally.

Reset
REQ-030 SHALL, while RESET is high at a clock edge, clear to 0: UART FSM (IDLE), parser (CMD), rx_data, rx_valid, frame_err, spikes, logs, all membranes, weights, thresholds, and L.
REQ-031 SHALL abort any frame in progress on reset, so that the first byte after reset release requires a fresh start bit.
REQ-032 SHALL set the synchroniser flops to 1 (idle) on reset.

Verification (CLKS_PER_BIT=4, N_NEURONS=4, VW=8)
REQ-033 SHALL cover: byte 0x5A sent -> rx_valid one pulse, rx_data=0x5A; 1-cycle low glitch on RXD -> no rx_valid.
REQ-034 SHALL cover: frame 0x33 sent with stop bit 0 -> frame_err=1, rx_data unchanged, parser still in CMD.
REQ-035 SHALL cover: 0x00,0x30 (w0=48); 0x40,0x64 (th0=100); 0x80,0x0F (L=15); 0xC0,0x01 three times -> v0 = 48, 96, then spikes=0001 on the third tick, v0=0, logs=1.
REQ-036 SHALL cover: w1=0x80 (-128), tick with gate bit1 -> v1 stays 0 (low saturation); w2=0x7F with th2=0, three ticks -> v2 = 127, 254, 255 (high saturation), no spike.
REQ-037 SHALL cover: 0x05,0x11 (index 5 >= N) -> no state change, and the next byte is parsed as CMD.
REQ-038 SHALL cover: RESET asserted mid-DATA -> all outputs 0 next cycle; a following byte 0xA5 is received correctly.

Source files
------------

// File: rtl/lif_array_uart_if.sv
// Bundle of the serial input and the neuron-array observation signals, so that a
// driver and the array see the same set of nets with explicit directions.
interface lif_array_uart_if #(
    parameter int N_NEURONS = 4
);
    logic                 rxd;
    logic [N_NEURONS-1:0] spikes;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic [7:0]           logs;

    modport master (
        output rxd,
        input  spikes, rx_data, rx_valid, frame_err, logs
    );

    modport slave (
        input  rxd,
        output spikes, rx_data, rx_valid, frame_err, logs
    );
endinterface

// File: rtl/lif_array_uart.sv
// Array of leaky integrate-and-fire neurons configured and ticked by a
// two-byte command protocol arriving on an 8N1 UART receiver.
module lif_array_uart #(
    parameter int N_NEURONS    = 4,
    parameter int VW           = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 RXD,
    output logic [N_NEURONS-1:0] spikes,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic [7:0]           logs
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ustate_t;
    typedef enum logic {P_CMD, P_ARG} pstate_t;

    // UART receiver state
    logic          rxd_s1_q, rxd_s2_q, rxd_prev_q;
    ustate_t       ust_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q;
    logic          frame_err_q;

    // Parser and neuron state
    pstate_t             pstate_q;
    logic [7:0]          cmd_q;
    logic [3:0]          leak_q;
    logic signed [7:0]   w_q  [N_NEURONS];
    logic [7:0]          th_q [N_NEURONS];
    logic [VW-1:0]       v_q  [N_NEURONS];
    logic [VW-1:0]       v_d  [N_NEURONS];
    logic [N_NEURONS-1:0] spikes_q, spikes_d, gate_w;
    logic [7:0]          logs_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rxd_s1_q    <= 1'b1;
            rxd_s2_q    <= 1'b1;
            rxd_prev_q  <= 1'b1;
            ust_q       <= U_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rxd_s1_q   <= RXD;
            rxd_s2_q   <= rxd_s1_q;
            rxd_prev_q <= rxd_s2_q;
            rx_valid_q <= 1'b0;
            case (ust_q)
                U_IDLE: begin
                    if (rxd_prev_q && !rxd_s2_q) begin
                        ust_q <= U_START;
                        cnt_q <= '0;
                    end
                end
                U_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        // A line that is high again at mid-bit was only a glitch
                        ust_q <= rxd_s2_q ? U_IDLE : U_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                U_DATA: begin
                    if (cnt_q == BIT_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rxd_s2_q, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            ust_q <= U_STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                U_STOP: begin
                    if (cnt_q == BIT_M1) begin
                        cnt_q <= '0;
                        ust_q <= U_IDLE;
                        if (rxd_s2_q) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ust_q <= U_IDLE;
            endcase
        end
    end

    logic       exec_w, tick_w;
    logic [1:0] op_w;
    logic [5:0] idx_w;

    assign exec_w = rx_valid_q && (pstate_q == P_ARG);
    assign op_w   = cmd_q[7:6];
    assign idx_w  = cmd_q[5:0];
    assign tick_w = exec_w && (op_w == 2'b11);

    // Per-neuron tick arithmetic, carried at VW+2 bits so both the negative
    // weight underflow and the v+weight overflow are visible before saturation.
    genvar gi;
    generate
        for (gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
            logic [VW+1:0] t_w;
            logic [VW-1:0] sat_w;
            logic          fire_w;

            if (gi < 8) begin : g_gated
                assign gate_w[gi] = rx_data_q[gi];
            end else begin : g_ungated
                assign gate_w[gi] = 1'b0;
            end

            assign t_w = {2'b00, v_q[gi]} - {2'b00, v_q[gi] >> leak_q}
                       + (gate_w[gi] ? (VW+2)'(w_q[gi]) : '0);
            assign sat_w  = t_w[VW+1] ? '0 : (t_w[VW] ? '1 : t_w[VW-1:0]);
            assign fire_w = (th_q[gi] != 8'd0) && (sat_w >= VW'(th_q[gi]));

            assign v_d[gi]      = tick_w ? (fire_w ? '0 : sat_w) : v_q[gi];
            assign spikes_d[gi] = tick_w && fire_w;
        end
    endgenerate

    function automatic logic [7:0] popcount(input logic [N_NEURONS-1:0] s);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            c = c + 8'(s[i]);
        end
        return c;
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pstate_q <= P_CMD;
            cmd_q    <= '0;
            leak_q   <= '0;
            spikes_q <= '0;
            logs_q   <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                w_q[i]  <= '0;
                th_q[i] <= '0;
                v_q[i]  <= '0;
            end
        end else begin
            if (rx_valid_q) begin
                if (pstate_q == P_CMD) begin
                    cmd_q    <= rx_data_q;
                    pstate_q <= P_ARG;
                end else begin
                    pstate_q <= P_CMD;
                end
            end
            if (exec_w && op_w == 2'b10) begin
                leak_q <= rx_data_q[3:0];
            end
            // Indices beyond the array match no neuron, so their ARG is simply consumed
            for (int i = 0; i < N_NEURONS; i++) begin
                if (exec_w && op_w == 2'b00 && idx_w == 6'(i)) begin
                    w_q[i] <= $signed(rx_data_q);
                end
                if (exec_w && op_w == 2'b01 && idx_w == 6'(i)) begin
                    th_q[i] <= rx_data_q;
                end
                v_q[i] <= v_d[i];
            end
            spikes_q <= spikes_d;
            logs_q   <= logs_q + popcount(spikes_q);
        end
    end

    assign spikes    = spikes_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign logs      = logs_q;
endmodule

// File: tb/tb_lif_array_uart.sv
// Bench for lif_array_uart: UART bytes driven bit by bit, received bytes checked
// against a queue, and a table of command pairs checked for spikes/membranes/logs.
module tb_lif_array_uart;
    localparam int N   = 4;
    localparam int VW  = 8;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lif_array_uart_if #(.N_NEURONS(N)) bus ();

    lif_array_uart #(
        .N_NEURONS    (N),
        .VW           (VW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .RXD       (bus.rxd),
        .spikes    (bus.spikes),
        .rx_data   (bus.rx_data),
        .rx_valid  (bus.rx_valid),
        .frame_err (bus.frame_err),
        .logs      (bus.logs)
    );

    int errors = 0;
    int checks = 0;
    int rx_count = 0;
    logic [7:0] exp_q[$];
    logic [N-1:0] spk_acc = '0;
    logic prev_valid = 1'b0;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] arg;
        logic [3:0] spk;
        logic [7:0] v0, v1, v2, v3;
        logic [7:0] logs;
    } vec_t;
    vec_t tbl[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: each received byte is matched against the oldest byte sent
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_valid) begin
                rx_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got byte 0x%0h, expected none", bus.rx_data);
                end else begin
                    chk("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
                end
            end
            if (bus.spikes != '0) begin
                spk_acc = spk_acc | bus.spikes;
                chk("spike_follows_arg", 32'(prev_valid), 32'd1);
            end
            prev_valid = bus.rx_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
        if (stop) exp_q.push_back(b);
        bus.rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.rxd = stop;
        repeat (CPB) @(negedge clk);
        bus.rxd = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic set_row(input int i, input logic [7:0] c, input logic [7:0] a,
                           input logic [3:0] s, input logic [7:0] v0, input logic [7:0] v1,
                           input logic [7:0] v2, input logic [7:0] v3, input logic [7:0] l);
        tbl[i].cmd = c;  tbl[i].arg = a;  tbl[i].spk = s;
        tbl[i].v0 = v0;  tbl[i].v1 = v1;  tbl[i].v2 = v2;  tbl[i].v3 = v3;
        tbl[i].logs = l;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        set_row( 0, 8'h00, 8'h30, 4'b0000, 8'd0,  8'd0, 8'd0,   8'd0, 8'd0);
        set_row( 1, 8'h40, 8'h64, 4'b0000, 8'd0,  8'd0, 8'd0,   8'd0, 8'd0);
        set_row( 2, 8'h80, 8'h0F, 4'b0000, 8'd0,  8'd0, 8'd0,   8'd0, 8'd0);
        set_row( 3, 8'hC0, 8'h01, 4'b0000, 8'd48, 8'd0, 8'd0,   8'd0, 8'd0);
        set_row( 4, 8'hC0, 8'h01, 4'b0000, 8'd96, 8'd0, 8'd0,   8'd0, 8'd0);
        set_row( 5, 8'hC0, 8'h01, 4'b0001, 8'd0,  8'd0, 8'd0,   8'd0, 8'd1);
        set_row( 6, 8'h01, 8'h80, 4'b0000, 8'd0,  8'd0, 8'd0,   8'd0, 8'd1);
        set_row( 7, 8'hC0, 8'h02, 4'b0000, 8'd0,  8'd0, 8'd0,   8'd0, 8'd1);
        set_row( 8, 8'h02, 8'h7F, 4'b0000, 8'd0,  8'd0, 8'd0,   8'd0, 8'd1);
        set_row( 9, 8'hC0, 8'h04, 4'b0000, 8'd0,  8'd0, 8'd127, 8'd0, 8'd1);
        set_row(10, 8'hC0, 8'h04, 4'b0000, 8'd0,  8'd0, 8'd254, 8'd0, 8'd1);
        set_row(11, 8'hC0, 8'h04, 4'b0000, 8'd0,  8'd0, 8'd255, 8'd0, 8'd1);
        set_row(12, 8'h05, 8'h11, 4'b0000, 8'd0,  8'd0, 8'd255, 8'd0, 8'd1);
        set_row(13, 8'h80, 8'h01, 4'b0000, 8'd0,  8'd0, 8'd255, 8'd0, 8'd1);
        set_row(14, 8'h42, 8'hC8, 4'b0000, 8'd0,  8'd0, 8'd255, 8'd0, 8'd1);
        set_row(15, 8'h03, 8'h0A, 4'b0000, 8'd0,  8'd0, 8'd255, 8'd0, 8'd1);
        set_row(16, 8'h43, 8'h05, 4'b0000, 8'd0,  8'd0, 8'd255, 8'd0, 8'd1);
        set_row(17, 8'hC0, 8'h0F, 4'b1100, 8'd48, 8'd0, 8'd0,   8'd0, 8'd3);
        set_row(18, 8'hC0, 8'h0D, 4'b1000, 8'd72, 8'd0, 8'd127, 8'd0, 8'd4);
        set_row(19, 8'hC0, 8'h0C, 4'b1000, 8'd36, 8'd0, 8'd191, 8'd0, 8'd5);
        set_row(20, 8'hC0, 8'h0C, 4'b1100, 8'd18, 8'd0, 8'd0,   8'd0, 8'd7);
        set_row(21, 8'hC0, 8'h00, 4'b0000, 8'd9,  8'd0, 8'd0,   8'd0, 8'd7);

        rst = 1'b1;
        bus.rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_rx_data", 32'(bus.rx_data), 32'd0);
        chk("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("reset_frame_err", 32'(bus.frame_err), 32'd0);
        chk("reset_spikes", 32'(bus.spikes), 32'd0);
        chk("reset_logs", 32'(bus.logs), 32'd0);

        // Plain byte, then its (ignored, index 26) argument
        send_byte(8'h5A, 1'b1, 8);
        chk("rx_count_5A", 32'(rx_count), 32'd1);
        chk("rx_data_5A", 32'(bus.rx_data), 32'h5A);
        send_byte(8'h00, 1'b1, 8);
        chk("rx_count_arg", 32'(rx_count), 32'd2);

        // One-cycle low glitch must not produce a byte
        bus.rxd = 1'b0;
        @(negedge clk);
        bus.rxd = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        chk("glitch_no_rx", 32'(rx_count), 32'd2);

        // Bad stop bit
        send_byte(8'h33, 1'b0, 8);
        chk("ferr_set", 32'(bus.frame_err), 32'd1);
        chk("ferr_rx_data_kept", 32'(bus.rx_data), 32'h00);
        chk("ferr_no_rx", 32'(rx_count), 32'd2);
        chk("ferr_parser_cmd", 32'(dut.pstate_q), 32'd0);

        // Command table; command byte sent back-to-back with its argument
        for (int r = 0; r < 22; r++) begin
            spk_acc = '0;
            send_byte(tbl[r].cmd, 1'b1, 0);
            send_byte(tbl[r].arg, 1'b1, 8);
            chk($sformatf("row%0d_spikes", r), 32'(spk_acc), 32'(tbl[r].spk));
            chk($sformatf("row%0d_v0", r), 32'(dut.v_q[0]), 32'(tbl[r].v0));
            chk($sformatf("row%0d_v1", r), 32'(dut.v_q[1]), 32'(tbl[r].v1));
            chk($sformatf("row%0d_v2", r), 32'(dut.v_q[2]), 32'(tbl[r].v2));
            chk($sformatf("row%0d_v3", r), 32'(dut.v_q[3]), 32'(tbl[r].v3));
            chk($sformatf("row%0d_logs", r), 32'(bus.logs), 32'(tbl[r].logs));
        end
        chk("rx_count_table", 32'(rx_count), 32'd46);

        // Reset in the middle of the data bits of a frame
        bus.rxd = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        rst = 1'b1;
        bus.rxd = 1'b1;
        @(negedge clk);
        chk("midrst_rx_data", 32'(bus.rx_data), 32'd0);
        chk("midrst_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("midrst_frame_err", 32'(bus.frame_err), 32'd0);
        chk("midrst_spikes", 32'(bus.spikes), 32'd0);
        chk("midrst_logs", 32'(bus.logs), 32'd0);
        chk("midrst_v0", 32'(dut.v_q[0]), 32'd0);
        rst = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        chk("midrst_no_rx", 32'(rx_count), 32'd46);
        send_byte(8'hA5, 1'b1, 8);
        chk("rx_count_A5", 32'(rx_count), 32'd47);
        chk("rx_data_A5", 32'(bus.rx_data), 32'hA5);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
